cr_writeback: RTL and testbench
===============================

# cr_writeback

Condition-register writeback stage sitting directly downstream of the compare unit and the CR-logical unit. Arbitrates their 4-bit CR-field results, writes the selected field into the architected 8×4-bit CR, and queues the producing reservation-station tag on a completion channel toward the rename/commit logic. It owns the CR state and exposes it to the dispatch stage.

## Interface
Parameters:
- RS_ID_WIDTH, 5, width of reservation-station tag
- FIFO_DEPTH, 4, completion-tag FIFO entries (power of 2, ≥2)

Ports:
- clk  in  1  clock; all state on rising edge
- rst  in  1  synchronous, active-high reset
- cmp_valid  in  1  compare result valid
- cmp_ready  out  1  compare result accepted when high with cmp_valid
- cmp_rs_id  in  RS_ID_WIDTH  producing tag
- cmp_addr  in  3  CR field index (0 = CR0, bits 0:3)
- cmp_result  in  4  LT,GT,EQ,SO
- crl_valid / crl_ready / crl_rs_id / crl_addr / crl_result: same widths and meaning, from CR-logical unit
- cpl_valid  out  1  completion tag available
- cpl_ready  in  1  consumer takes tag
- cpl_rs_id  out  RS_ID_WIDTH  completed tag
- cr_out  out  32  architected CR, bit 0 = CR0[LT]

## Operation
- Grant: at most one source per cycle. Only valid sources compete; if both valid, round-robin on last_grant register (grant the source not granted last). Reset value of last_grant = crl, so cmp wins first tie.
- Source ready: cmp_ready = ~full & grant_cmp; crl_ready = ~full & grant_crl. Ready may depend on valid (valid must not depend on ready). last_grant updates only on an actual transfer.
- On transfer: CR field addr ← result (bits 4·addr to 4·addr+3), other fields unchanged; rs_id pushed to completion FIFO.
- Completion FIFO: registered storage, read/write pointers with log2(FIFO_DEPTH) bits wrapping modulo depth, count of log2(FIFO_DEPTH)+1 bits. cpl_valid = count≠0; cpl_rs_id = entry at read pointer. Pop when cpl_valid & cpl_ready.
- Full: no push while full even if pop occurs same cycle (ready = ~full, no pass-through). Push and pop in same non-full, non-empty cycle: count unchanged, both pointers advance.
- Empty: no bypass; a push into empty FIFO appears on cpl_* next cycle.
- Reset (any time, including mid-transfer): CR = 0, pointers and count = 0, last_grant = crl; in-flight transfer in that cycle is discarded.

## Timing
- Reset values: cmp_ready = crl_ready = 0 only if no valid input (combinational, FIFO empty so ready follows grant), cpl_valid = 0, cpl_rs_id = 0 (storage cleared), cr_out = 0.
- Transfer at edge N → cr_out reflects new field after edge N; cpl_valid high after edge N if FIFO was empty.
- Throughput: one transfer per cycle while cpl_ready held high.
- Tags complete in transfer order.

## Configuration
- CR_WB_BYPASS_EN defined: cr_out combinationally merges the field being transferred this cycle (same-cycle visibility for dispatch); zero-latency CR read.
- Undefined: cr_out is the register only; new value one cycle after transfer.

## Structure
- ppc_types package: cr_field_t (logic[0:3]), cr_addr_t (logic[0:2]), cr_src_e {CR_SRC_CMP, CR_SRC_CRL}.
- One sub-module: cr_tag_fifo (parameterised depth/width, valid/ready both sides, full/empty flags); arbiter and CR register stay in cr_writeback.

## Test plan
- Reset then cmp addr=0 result=4'b1000 rs_id=3 → cr_out=32'h8000_0000 next cycle; cpl_valid=1, cpl_rs_id=3.
- Both valid every cycle, cmp addr=1 val=4'b0100, crl addr=7 val=4'b0011, cpl_ready=1 → grants alternate cmp,crl,cmp…; cr_out=32'h0400_0003.
- cpl_ready=0, FIFO_DEPTH=4, five cmp transfers attempted → four accepted, cmp_ready=0 on fifth; assert cpl_ready → tags drain in order, fifth accepted after first pop.
- Full FIFO with cpl_ready=1 and cmp_valid=1 → pop occurs, no push that cycle; push next cycle.
- Fill 3 entries, pulse rst → cpl_valid=0, cr_out=0 next cycle, subsequent tie grants cmp.
- With CR_WB_BYPASS_EN: crl addr=2 val=4'b1111 → cr_out=32'h00F0_0000 same cycle as transfer; without macro, one cycle later.

Source files
------------

// File: rtl/ppc_types_pkg.sv
// ppc_types: shared condition-register types for the writeback slice.
//   cr_field_t : one 4-bit CR field, bit 0 = LT, 1 = GT, 2 = EQ, 3 = SO
//   cr_addr_t  : CR field index, 0 = CR0 (most significant nibble of the CR)
//   cr_src_e   : which producer a CR result came from
//   cr_merge() : returns a 32-bit CR with one field replaced
package ppc_types;

  typedef logic [0:3] cr_field_t;
  typedef logic [0:2] cr_addr_t;

  typedef enum logic {
    CR_SRC_CMP = 1'b0,
    CR_SRC_CRL = 1'b1
  } cr_src_e;

  localparam int CR_FIELDS = 8;

  // The CR uses big-endian bit numbering: bit 0 is the MSB, field n spans
  // bits 4n..4n+3, so an ascending vector makes the slice arithmetic direct.
  function automatic logic [0:31] cr_merge(input logic [0:31] cr,
                                           input cr_addr_t    addr,
                                           input cr_field_t   field);
    logic [0:31] r;
    r = cr;
    r[4*int'(addr) +: 4] = field;
    return r;
  endfunction

endpackage

// File: rtl/cr_writeback_fifo.sv
// cr_tag_fifo: registered completion-tag FIFO.
//   clk, rst                    : clock, synchronous active-high reset
//   in_valid/in_ready/in_data   : push side; in_ready = ~full (no pass-through)
//   out_valid/out_ready/out_data: pop side; out_data = entry at read pointer
//   full, empty                 : occupancy flags
// DEPTH must be a power of two (>= 2) so the pointers wrap naturally.
module cr_tag_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] DEPTH_CNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wptr;
  logic [AW-1:0]    rptr;
  logic [AW:0]      count;
  logic             push;
  logic             pop;

  assign full      = (count == DEPTH_CNT);
  assign empty     = (count == '0);
  assign in_ready  = ~full;
  assign out_valid = ~empty;
  assign out_data  = mem[rptr];
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
      // Storage is cleared so the tag output reads zero after reset.
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (push) begin
        mem[wptr] <= in_data;
        wptr      <= wptr + 1'b1;
      end
      if (pop) rptr <= rptr + 1'b1;
      if (push && !pop)      count <= count + 1'b1;
      else if (pop && !push) count <= count - 1'b1;
    end
  end

endmodule

// File: rtl/cr_writeback.sv
// cr_writeback: condition-register writeback stage.
// Arbitrates compare (cmp_*) and CR-logical (crl_*) field results, writes the
// winner into the architected 8 x 4-bit CR and queues its reservation-station
// tag on the completion channel (cpl_*).
//   clk, rst        : clock, synchronous active-high reset
//   cmp_* / crl_*   : producer channels (valid, ready, rs_id, addr, result)
//   cpl_*           : completion-tag channel toward rename/commit
//   cr_out          : architected CR, bit 31 here = CR0[LT] (PowerPC bit 0)
// Handshake: a transfer happens on a rising edge where valid and ready are both
// high. Ready may depend on valid; valid never depends on ready. Producers hold
// their payload stable while valid is high and ready is low.
// Optional build macro: CR_WB_BYPASS_EN -- cr_out also shows the field being
// written this cycle (zero-latency CR read). Without it cr_out is registered.
module cr_writeback
  import ppc_types::*;
#(
  parameter int RS_ID_WIDTH = 5,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   cmp_valid,
  output logic                   cmp_ready,
  input  logic [RS_ID_WIDTH-1:0] cmp_rs_id,
  input  cr_addr_t               cmp_addr,
  input  cr_field_t              cmp_result,
  input  logic                   crl_valid,
  output logic                   crl_ready,
  input  logic [RS_ID_WIDTH-1:0] crl_rs_id,
  input  cr_addr_t               crl_addr,
  input  cr_field_t              crl_result,
  output logic                   cpl_valid,
  input  logic                   cpl_ready,
  output logic [RS_ID_WIDTH-1:0] cpl_rs_id,
  output logic [31:0]            cr_out
);

  cr_src_e                last_grant;
  logic [0:31]            cr_q;
  logic [0:31]            cr_next;
  logic                   grant_cmp;
  logic                   grant_crl;
  logic                   any_valid;
  logic                   xfer;
  logic [RS_ID_WIDTH-1:0] sel_rs_id;
  cr_addr_t               sel_addr;
  cr_field_t              sel_result;
  logic                   fifo_in_ready;
  logic                   fifo_out_valid;
  logic                   fifo_full;
  logic                   fifo_empty;

  // Round-robin: on a tie the source that did not win last time goes first.
  assign grant_cmp = cmp_valid & (~crl_valid | (last_grant == CR_SRC_CRL));
  assign grant_crl = crl_valid & ~grant_cmp;
  assign any_valid = cmp_valid | crl_valid;

  assign cmp_ready = ~fifo_full & grant_cmp;
  assign crl_ready = ~fifo_full & grant_crl;
  assign xfer      = any_valid & fifo_in_ready;

  assign sel_rs_id  = grant_cmp ? cmp_rs_id  : crl_rs_id;
  assign sel_addr   = grant_cmp ? cmp_addr   : crl_addr;
  assign sel_result = grant_cmp ? cmp_result : crl_result;
  assign cr_next    = cr_merge(cr_q, sel_addr, sel_result);

  always_ff @(posedge clk) begin
    if (rst) begin
      cr_q       <= '0;
      last_grant <= CR_SRC_CRL;
    end else if (xfer) begin
      cr_q       <= cr_next;
      last_grant <= grant_cmp ? CR_SRC_CMP : CR_SRC_CRL;
    end
  end

`ifdef CR_WB_BYPASS_EN
  assign cr_out = xfer ? cr_next : cr_q;
`else
  assign cr_out = cr_q;
`endif

  cr_tag_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (RS_ID_WIDTH)
  ) u_tag_fifo (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (any_valid),
    .in_ready  (fifo_in_ready),
    .in_data   (sel_rs_id),
    .out_valid (fifo_out_valid),
    .out_ready (cpl_ready),
    .out_data  (cpl_rs_id),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  assign cpl_valid = fifo_out_valid;

  // The FIFO flags and handshake outputs must always agree.
  flags_consistent: assert property (@(posedge clk) disable iff (rst)
    (fifo_in_ready == ~fifo_full) && (fifo_out_valid == ~fifo_empty));

endmodule

// File: tb/tb_cr_writeback.sv
module tb_cr_writeback;

  localparam int RS    = 5;
  localparam int DEPTH = 4;

  // clock / reset
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic          cmp_valid = 1'b0, crl_valid = 1'b0, cpl_ready = 1'b0;
  logic          cmp_ready, crl_ready, cpl_valid;
  logic [RS-1:0] cmp_rs_id = '0, crl_rs_id = '0, cpl_rs_id;
  logic [2:0]    cmp_addr = '0, crl_addr = '0;
  logic [3:0]    cmp_result = '0, crl_result = '0;
  logic [31:0]   cr_out;

  cr_writeback #(.RS_ID_WIDTH(RS), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .cmp_valid(cmp_valid), .cmp_ready(cmp_ready), .cmp_rs_id(cmp_rs_id),
    .cmp_addr(cmp_addr), .cmp_result(cmp_result),
    .crl_valid(crl_valid), .crl_ready(crl_ready), .crl_rs_id(crl_rs_id),
    .crl_addr(crl_addr), .crl_result(crl_result),
    .cpl_valid(cpl_valid), .cpl_ready(cpl_ready), .cpl_rs_id(cpl_rs_id),
    .cr_out(cr_out)
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %h, expected %h", name, $time, act, exp);
    end
  endtask

  // reference model: tag queue, CR as 8 nibbles, who won last, fresh-reset flag
  logic [RS-1:0] exp_q[$];
  logic [3:0]    cr_m[8] = '{default: 4'h0};
  bit            last_cmp = 1'b0;
  bit            fresh = 1'b1;

  function automatic logic [31:0] model_cr(input int upd_addr, input logic [3:0] upd_val);
    logic [31:0] v;
    for (int i = 0; i < 8; i++) v[31-4*i -: 4] = (i == upd_addr) ? upd_val : cr_m[i];
    return v;
  endfunction

  // scoreboard: outputs are stable mid-cycle; model advances as the next edge will
  always @(negedge clk) begin
    bit full, gc, gl, push, pop;
    logic [31:0] ecr;
    full = (exp_q.size() == DEPTH);
    gc   = cmp_valid && (!crl_valid || !last_cmp);
    gl   = crl_valid && !gc;
    push = !full && (gc || gl);
    check("cmp_ready", {31'b0, cmp_ready}, {31'b0, !full && gc});
    check("crl_ready", {31'b0, crl_ready}, {31'b0, !full && gl});
    check("cpl_valid", {31'b0, cpl_valid}, {31'b0, exp_q.size() != 0});
    if (exp_q.size() != 0) check("cpl_rs_id", {27'b0, cpl_rs_id}, {27'b0, exp_q[0]});
    else if (fresh)        check("cpl_rs_id_rst", {27'b0, cpl_rs_id}, 32'h0);
`ifdef CR_WB_BYPASS_EN
    if (push) ecr = model_cr(gc ? int'(cmp_addr) : int'(crl_addr), gc ? cmp_result : crl_result);
    else      ecr = model_cr(-1, 4'h0);
`else
    ecr = model_cr(-1, 4'h0);
`endif
    check("cr_out", cr_out, ecr);
    if (rst) begin
      exp_q.delete();
      for (int i = 0; i < 8; i++) cr_m[i] = 4'h0;
      last_cmp = 1'b0;
      fresh    = 1'b1;
    end else begin
      pop = (exp_q.size() != 0) && cpl_ready;
      if (pop) void'(exp_q.pop_front());
      if (push) begin
        exp_q.push_back(gc ? cmp_rs_id : crl_rs_id);
        if (gc) cr_m[cmp_addr] = cmp_result;
        else    cr_m[crl_addr] = crl_result;
        last_cmp = gc;
        fresh    = 1'b0;
      end
    end
  end

  // driver tasks
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  task automatic idle();
    cmp_valid = 1'b0;
    crl_valid = 1'b0;
  endtask

  task automatic drive_cmp(input int a, input int r, input int id);
    cmp_valid = 1'b1; cmp_addr = 3'(a); cmp_result = 4'(r); cmp_rs_id = RS'(id);
  endtask

  task automatic drive_crl(input int a, input int r, input int id);
    crl_valid = 1'b1; crl_addr = 3'(a); crl_result = 4'(r); crl_rs_id = RS'(id);
  endtask

  initial begin
    repeat (2) step();
    rst = 1'b0;
    #2;
    check("rst_cr_out", cr_out, 32'h0);
    check("rst_cpl_valid", {31'b0, cpl_valid}, 32'h0);
    check("rst_cpl_rs_id", {27'b0, cpl_rs_id}, 32'h0);

    // single compare write into CR0
    step();
    drive_cmp(0, 4'b1000, 3);
    #2 check("t1_cmp_ready", {31'b0, cmp_ready}, 32'h1);
    step();
    idle();
    #2;
    check("t1_cr_out", cr_out, 32'h8000_0000);
    check("t1_cpl_valid", {31'b0, cpl_valid}, 32'h1);
    check("t1_cpl_rs_id", {27'b0, cpl_rs_id}, 32'd3);
    cpl_ready = 1'b1;
    step();

    // CR-logical write into CR2; visibility depends on the bypass build
    do_reset();
    drive_crl(2, 4'b1111, 7);
    #2;
    check("t6_crl_ready", {31'b0, crl_ready}, 32'h1);
`ifdef CR_WB_BYPASS_EN
    check("t6_cr_same_cycle", cr_out, 32'h00F0_0000);
`else
    check("t6_cr_same_cycle", cr_out, 32'h0);
`endif
    step();
    idle();
    #2 check("t6_cr_next_cycle", cr_out, 32'h00F0_0000);

    // both sources valid every cycle: grants alternate starting with cmp
    do_reset();
    cpl_ready = 1'b1;
    drive_cmp(1, 4'b0100, 1);
    drive_crl(7, 4'b0011, 2);
    for (int i = 0; i < 6; i++) begin
      #2;
      check("t2_cmp_grant", {31'b0, cmp_ready}, {31'b0, (i % 2) == 0});
      check("t2_crl_grant", {31'b0, crl_ready}, {31'b0, (i % 2) == 1});
      step();
    end
    idle();
    #2 check("t2_cr_out", cr_out, 32'h0400_0003);

    // fill to full, fifth rejected, drain in order, pop frees one slot
    do_reset();
    cpl_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      drive_cmp(i, i, 10 + i);
      #2 check("t3_fill_ready", {31'b0, cmp_ready}, {31'b0, i < 4});
      step();
    end
    cpl_ready = 1'b1;
    #2;
    check("t3_full_pop_ready", {31'b0, cmp_ready}, 32'h0);
    check("t3_head0", {27'b0, cpl_rs_id}, 32'd10);
    step();
    #2;
    check("t3_after_pop_ready", {31'b0, cmp_ready}, 32'h1);
    check("t3_head1", {27'b0, cpl_rs_id}, 32'd11);
    step();
    idle();
    for (int k = 0; k < 3; k++) begin
      #2 check("t3_drain", {27'b0, cpl_rs_id}, 32'(12 + k));
      step();
    end
    #2 check("t3_empty", {31'b0, cpl_valid}, 32'h0);

    // reset with entries queued and a transfer in flight
    do_reset();
    cpl_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      drive_cmp(i, 4'hA, 20 + i);
      step();
    end
    idle();
    drive_crl(5, 4'h5, 9);
    rst = 1'b1;
    step();
    rst = 1'b0;
    idle();
    #2;
    check("t5_cpl_valid", {31'b0, cpl_valid}, 32'h0);
    check("t5_cr_out", cr_out, 32'h0);
    step();
    drive_cmp(3, 4'h1, 4);
    drive_crl(4, 4'h2, 5);
    #2;
    check("t5_tie_cmp", {31'b0, cmp_ready}, 32'h1);
    check("t5_tie_crl", {31'b0, crl_ready}, 32'h0);
    step();
    idle();

    // randomized traffic with occasional resets
    for (int n = 0; n < 3000; n++) begin
      rst        = ($urandom_range(0, 99) == 0);
      cmp_valid  = ($urandom_range(0, 99) < 60);
      crl_valid  = ($urandom_range(0, 99) < 60);
      cmp_addr   = 3'($urandom_range(0, 7));
      crl_addr   = 3'($urandom_range(0, 7));
      cmp_result = 4'($urandom_range(0, 15));
      crl_result = 4'($urandom_range(0, 15));
      cmp_rs_id  = RS'($urandom_range(0, 31));
      crl_rs_id  = RS'($urandom_range(0, 31));
      cpl_ready  = ($urandom_range(0, 99) < 55);
      step();
    end
    rst = 1'b0;
    idle();
    cpl_ready = 1'b1;
    repeat (6) step();

    // final report
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
